mmu_walk_responder: RTL and testbench

- Memory-side responder for the MMU page-table-walk port: accepts 32-bit walk read requests and issues them as 64-bit-aligned reads to the backing memory bus.
- Returns each 64-bit memory word to the MMU in request order.
- Provides REQ/LOCK and VALID/LOCK flow control on both sides, with credit-based back-pressure so responses are never dropped.
- Sits between the MMU walk port and the memory arbiter.

---
 rtl/mmu_walk_responder.sv | 179 +++++++++++++++++
 tb/tb_mmu_walk_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_walk_responder.sv
// MMU page-table-walk responder.
// Accepts 32-bit walk reads from the MMU, forwards them as 8-byte-aligned
// reads to the memory arbiter, and returns the 64-bit words to the MMU in
// request order. The requests queued, outstanding and buffered together may
// never exceed DEPTH, so a returning word always has a slot waiting for it.
module mmu_walk_responder #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  // MMU walk request side
  input  logic        iMMU_REQ,
  output logic        oMMU_LOCK,
  input  logic [31:0] iMMU_ADDR,
  // MMU response side
  output logic        oMMU_VALID,
  input  logic        iMMU_LOCK,
  output logic [63:0] oMMU_DATA,
  // memory request side
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic [31:0] oMEM_ADDR,
  // memory return side
  input  logic        iMEM_VALID,
  output logic        oMEM_LOCK,
  input  logic [63:0] iMEM_DATA,
  // status
  output logic        oBUSY,
  output logic        oERROR
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);
  localparam logic [PW-1:0] ONE_PTR  = PW'(1);

  // Request FIFO: walk addresses waiting to be issued to memory
  logic [31:0]   req_mem [DEPTH];
  logic [PW-1:0] req_wptr_reg, req_wptr_next;
  logic [PW-1:0] req_rptr_reg, req_rptr_next;
  logic [CW-1:0] req_cnt_reg,  req_cnt_next;

  // Reads issued to memory whose data has not come back yet
  logic [CW-1:0] out_cnt_reg,  out_cnt_next;

  // Response FIFO: memory words waiting for the MMU
  logic [63:0]   rsp_mem [DEPTH];
  logic [PW-1:0] rsp_wptr_reg, rsp_wptr_next;
  logic [PW-1:0] rsp_rptr_reg, rsp_rptr_next;
  logic [CW-1:0] rsp_cnt_reg,  rsp_cnt_next;

  logic          error_reg,    error_next;

  logic [CW-1:0] used;
  logic          mmu_lock;
  logic          mem_req;
  logic          mem_lock;
  logic          mmu_valid;
  logic [31:0]   req_head;
  logic [63:0]   rsp_head;

  logic          accept;
  logic          issue;
  logic          capture;
  logic          stray;
  logic          pop;

  // Credit and handshake decode; everything here comes from registers or
  // from the partner's LOCK/VALID, never from iMMU_REQ into oMMU_LOCK.
  always_comb begin
    used      = req_cnt_reg + out_cnt_reg + rsp_cnt_reg;
    mmu_lock  = (used == FULL_CNT);
    mem_req   = (req_cnt_reg != '0);
    mem_lock  = (rsp_cnt_reg == FULL_CNT);
    mmu_valid = (rsp_cnt_reg != '0);
    req_head  = req_mem[req_rptr_reg];
    rsp_head  = rsp_mem[rsp_rptr_reg];

    accept    = iMMU_REQ && !mmu_lock;
    issue     = mem_req && !iMEM_LOCK;
    capture   = iMEM_VALID && !mem_lock && (out_cnt_reg != '0);
    stray     = iMEM_VALID && (out_cnt_reg == '0);
    pop       = mmu_valid && !iMMU_LOCK;
  end

  // Next-state for pointers, counters and the sticky error flag
  always_comb begin
    req_wptr_next = req_wptr_reg;
    req_rptr_next = req_rptr_reg;
    req_cnt_next  = req_cnt_reg;
    out_cnt_next  = out_cnt_reg;
    rsp_wptr_next = rsp_wptr_reg;
    rsp_rptr_next = rsp_rptr_reg;
    rsp_cnt_next  = rsp_cnt_reg;
    error_next    = error_reg || stray;

    if (accept) begin
      req_wptr_next = req_wptr_reg + ONE_PTR;
    end
    if (issue) begin
      req_rptr_next = req_rptr_reg + ONE_PTR;
    end
    if (accept && !issue) begin
      req_cnt_next = req_cnt_reg + ONE_CNT;
    end else if (!accept && issue) begin
      req_cnt_next = req_cnt_reg - ONE_CNT;
    end

    if (issue && !capture) begin
      out_cnt_next = out_cnt_reg + ONE_CNT;
    end else if (!issue && capture) begin
      out_cnt_next = out_cnt_reg - ONE_CNT;
    end

    if (capture) begin
      rsp_wptr_next = rsp_wptr_reg + ONE_PTR;
    end
    if (pop) begin
      rsp_rptr_next = rsp_rptr_reg + ONE_PTR;
    end
    if (capture && !pop) begin
      rsp_cnt_next = rsp_cnt_reg + ONE_CNT;
    end else if (!capture && pop) begin
      rsp_cnt_next = rsp_cnt_reg - ONE_CNT;
    end
  end

  // Control state; reset discards every queued, outstanding and buffered entry
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      req_wptr_reg <= '0;
      req_rptr_reg <= '0;
      req_cnt_reg  <= '0;
      out_cnt_reg  <= '0;
      rsp_wptr_reg <= '0;
      rsp_rptr_reg <= '0;
      rsp_cnt_reg  <= '0;
      error_reg    <= 1'b0;
    end else begin
      req_wptr_reg <= req_wptr_next;
      req_rptr_reg <= req_rptr_next;
      req_cnt_reg  <= req_cnt_next;
      out_cnt_reg  <= out_cnt_next;
      rsp_wptr_reg <= rsp_wptr_next;
      rsp_rptr_reg <= rsp_rptr_next;
      rsp_cnt_reg  <= rsp_cnt_next;
      error_reg    <= error_next;
    end
  end

  // Request storage; contents need no reset because the count gates every read
  always_ff @(posedge iCLOCK) begin
    if (accept) begin
      req_mem[req_wptr_reg] <= iMMU_ADDR;
    end
  end

  // Response storage; written only for solicited, accepted memory data
  always_ff @(posedge iCLOCK) begin
    if (capture) begin
      rsp_mem[rsp_wptr_reg] <= iMEM_DATA;
    end
  end

  // Outputs; address and data are forced to zero when their FIFO is empty so
  // stale storage never leaks onto the buses
  always_comb begin
    oMMU_LOCK  = mmu_lock;
    oMEM_REQ   = mem_req;
    oMEM_ADDR  = mem_req ? {req_head[31:3], 3'b000} : 32'd0;
    oMEM_LOCK  = mem_lock;
    oMMU_VALID = mmu_valid;
    oMMU_DATA  = mmu_valid ? rsp_head : 64'd0;
    oBUSY      = (used != '0);
    oERROR     = error_reg;
  end

endmodule

// File: tb/tb_mmu_walk_responder.sv
// Directed bench for mmu_walk_responder (DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, and no output has a combinational path from an input. An optional
// memory stand-in answers each issued read exactly one cycle later with
// {32'hDA7A_0000, address}.
module tb_mmu_walk_responder;

  logic        clk;
  logic        rst_n;
  logic        iMMU_REQ;
  logic        oMMU_LOCK;
  logic [31:0] iMMU_ADDR;
  logic        oMMU_VALID;
  logic        iMMU_LOCK;
  logic [63:0] oMMU_DATA;
  logic        oMEM_REQ;
  logic        iMEM_LOCK;
  logic [31:0] oMEM_ADDR;
  logic        iMEM_VALID;
  logic        oMEM_LOCK;
  logic [63:0] iMEM_DATA;
  logic        oBUSY;
  logic        oERROR;

  int n_assert = 0;
  int n_fail   = 0;
  logic mem_auto = 1'b0;

  mmu_walk_responder #(.DEPTH(4), .CW(3)) dut (
    .iCLOCK     (clk),
    .inRESET    (rst_n),
    .iMMU_REQ   (iMMU_REQ),
    .oMMU_LOCK  (oMMU_LOCK),
    .iMMU_ADDR  (iMMU_ADDR),
    .oMMU_VALID (oMMU_VALID),
    .iMMU_LOCK  (iMMU_LOCK),
    .oMMU_DATA  (oMMU_DATA),
    .oMEM_REQ   (oMEM_REQ),
    .iMEM_LOCK  (iMEM_LOCK),
    .oMEM_ADDR  (oMEM_ADDR),
    .iMEM_VALID (iMEM_VALID),
    .oMEM_LOCK  (oMEM_LOCK),
    .iMEM_DATA  (iMEM_DATA),
    .oBUSY      (oBUSY),
    .oERROR     (oERROR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample the memory handshake before the edge, then (if enabled)
  // return that read's data in the following cycle.
  task automatic tick();
    logic        iss;
    logic [31:0] a;
    iss = oMEM_REQ && !iMEM_LOCK;
    a   = oMEM_ADDR;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      iMEM_VALID = iss;
      iMEM_DATA  = iss ? {32'hDA7A_0000, a} : 64'd0;
    end
  endtask

  initial begin
    int sent;
    int got;
    logic acc;
    logic [63:0] exp_d;

    rst_n      = 1'b1;
    iMMU_REQ   = 1'b0;
    iMMU_ADDR  = 32'd0;
    iMMU_LOCK  = 1'b0;
    iMEM_LOCK  = 1'b0;
    iMEM_VALID = 1'b0;
    iMEM_DATA  = 64'd0;

    // ---- reset state ----
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mmu_lock",  64'(oMMU_LOCK),  64'd0);
    chk("rst_mmu_valid", 64'(oMMU_VALID), 64'd0);
    chk("rst_mmu_data",  oMMU_DATA,       64'd0);
    chk("rst_mem_req",   64'(oMEM_REQ),   64'd0);
    chk("rst_mem_addr",  64'(oMEM_ADDR),  64'd0);
    chk("rst_mem_lock",  64'(oMEM_LOCK),  64'd0);
    chk("rst_busy",      64'(oBUSY),      64'd0);
    chk("rst_error",     64'(oERROR),     64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ---- single walk, manual memory ----
    iMMU_REQ = 1'b1; iMMU_ADDR = 32'h0000_1234;      // cycle N: accept
    tick();
    iMMU_REQ = 1'b0;                                 // N+1: issue
    chk("walk_mem_req",  64'(oMEM_REQ),  64'd1);
    chk("walk_mem_addr", 64'(oMEM_ADDR), 64'h0000_1230);
    chk("walk_busy",     64'(oBUSY),     64'd1);
    tick();
    chk("walk_mem_req_done", 64'(oMEM_REQ), 64'd0); // N+2: data returns
    chk("walk_no_early_valid", 64'(oMMU_VALID), 64'd0);
    iMEM_VALID = 1'b1; iMEM_DATA = 64'h1111_2222_3333_4444;
    tick();
    iMEM_VALID = 1'b0; iMEM_DATA = 64'd0;            // N+3: response visible
    chk("walk_valid", 64'(oMMU_VALID), 64'd1);
    chk("walk_data",  oMMU_DATA, 64'h1111_2222_3333_4444);
    tick();
    chk("walk_valid_once", 64'(oMMU_VALID), 64'd0);
    chk("walk_data_zero",  oMMU_DATA, 64'd0);
    chk("walk_idle",       64'(oBUSY), 64'd0);
    chk("walk_no_error",   64'(oERROR), 64'd0);

    // ---- credit fill with memory locked ----
    mem_auto  = 1'b1;
    iMEM_LOCK = 1'b1;
    iMMU_REQ  = 1'b1;
    iMMU_ADDR = 32'h200; tick();
    iMMU_ADDR = 32'h208; tick();
    iMMU_ADDR = 32'h210; tick();
    chk("fill_lock_at3", 64'(oMMU_LOCK), 64'd0);
    iMMU_ADDR = 32'h218; tick();
    iMMU_ADDR = 32'h220;                              // 5th request, must be held
    chk("fill_lock_full",  64'(oMMU_LOCK), 64'd1);
    chk("fill_mem_addr",   64'(oMEM_ADDR), 64'h200);
    tick();
    chk("fill_lock_held",  64'(oMMU_LOCK), 64'd1);
    chk("fill_addr_stable", 64'(oMEM_ADDR), 64'h200);
    chk("fill_req_stable",  64'(oMEM_REQ),  64'd1);
    iMEM_LOCK = 1'b0;                                 // C0: issue 0x200
    tick();                                           // C1: D200 captured, issue 0x208
    chk("fill_lock_c1", 64'(oMMU_LOCK), 64'd1);
    tick();                                           // C2: pop D200
    chk("fill_first_valid", 64'(oMMU_VALID), 64'd1);
    chk("fill_first_data",  oMMU_DATA, 64'hDA7A_0000_0000_0200);
    chk("fill_lock_on_pop", 64'(oMMU_LOCK), 64'd1);
    tick();                                           // C3: credit freed, 5th accepted
    chk("fill_lock_freed", 64'(oMMU_LOCK), 64'd0);
    chk("fill_second_data", oMMU_DATA, 64'hDA7A_0000_0000_0208);
    tick();
    iMMU_REQ = 1'b0;
    chk("fill_fifth_issued", 64'(oMEM_ADDR), 64'h220);
    chk("fill_third_data",   oMMU_DATA, 64'hDA7A_0000_0000_0210);
    for (int i = 0; i < 20 && oBUSY; i++) tick();
    chk("fill_drained", 64'(oBUSY), 64'd0);

    // ---- response back-pressure ----
    iMMU_LOCK = 1'b1;
    iMMU_REQ  = 1'b1;
    iMMU_ADDR = 32'h300; tick();
    iMMU_ADDR = 32'h308; tick();
    iMMU_ADDR = 32'h310; tick();
    iMMU_REQ  = 1'b0;
    tick();
    chk("bp_hold_valid", 64'(oMMU_VALID), 64'd1);
    chk("bp_hold_data0", oMMU_DATA, 64'hDA7A_0000_0000_0300);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_hold_data1", oMMU_DATA, 64'hDA7A_0000_0000_0300);
    chk("bp_all_issued", 64'(oMEM_REQ), 64'd0);
    iMMU_LOCK = 1'b0;
    tick();
    chk("bp_deliver1", oMMU_DATA, 64'hDA7A_0000_0000_0308);
    tick();
    chk("bp_deliver2", oMMU_DATA, 64'hDA7A_0000_0000_0310);
    tick();
    chk("bp_empty", 64'(oMMU_VALID), 64'd0);
    chk("bp_idle",  64'(oBUSY), 64'd0);

    // ---- unsolicited memory data ----
    mem_auto = 1'b0;
    iMEM_VALID = 1'b1; iMEM_DATA = 64'hDEAD_BEEF_0000_0001;
    tick();
    iMEM_VALID = 1'b0; iMEM_DATA = 64'd0;
    chk("stray_no_valid", 64'(oMMU_VALID), 64'd0);
    chk("stray_error",    64'(oERROR), 64'd1);
    chk("stray_not_busy", 64'(oBUSY), 64'd0);
    tick();
    tick();
    chk("stray_error_sticky", 64'(oERROR), 64'd1);

    // ---- reset with two reads outstanding ----
    iMMU_REQ = 1'b1;
    iMMU_ADDR = 32'h400; tick();
    iMMU_ADDR = 32'h408; tick();
    iMMU_REQ = 1'b0;
    tick();
    tick();
    chk("mid_busy", 64'(oBUSY), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  64'(oBUSY),     64'd0);
    chk("mid_rst_error", 64'(oERROR),    64'd0);
    chk("mid_rst_req",   64'(oMEM_REQ),  64'd0);
    chk("mid_rst_valid", 64'(oMMU_VALID), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    iMEM_VALID = 1'b1; iMEM_DATA = 64'h0000_0000_0000_0400;   // late pre-reset data
    tick();
    iMEM_VALID = 1'b0; iMEM_DATA = 64'd0;
    chk("post_rst_stray_error", 64'(oERROR), 64'd1);
    chk("post_rst_no_valid",    64'(oMMU_VALID), 64'd0);
    iMMU_REQ = 1'b1; iMMU_ADDR = 32'h0000_0504;
    tick();
    iMMU_REQ = 1'b0;
    chk("fresh_mem_addr", 64'(oMEM_ADDR), 64'h0000_0500);
    tick();
    iMEM_VALID = 1'b1; iMEM_DATA = 64'h5555_6666_7777_8888;
    tick();
    iMEM_VALID = 1'b0; iMEM_DATA = 64'd0;
    chk("fresh_data", oMMU_DATA, 64'h5555_6666_7777_8888);
    tick();
    chk("fresh_idle", 64'(oBUSY), 64'd0);

    // ---- pointer wrap with random locks on both sides ----
    mem_auto = 1'b1;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      iMEM_LOCK = ($urandom_range(0, 3) == 0);
      iMMU_LOCK = ($urandom_range(0, 2) == 0);
      iMMU_REQ  = (sent < 10);
      iMMU_ADDR = 32'h100 + 32'(8 * sent);
      acc = iMMU_REQ && !oMMU_LOCK;
      if (oMMU_VALID && !iMMU_LOCK) begin
        exp_d = {32'hDA7A_0000, 32'h100 + 32'(8 * got)};
        chk("wrap_data", oMMU_DATA, exp_d);
        got++;
      end
      tick();
      if (acc) sent++;
    end
    iMMU_REQ  = 1'b0;
    iMEM_LOCK = 1'b0;
    iMMU_LOCK = 1'b0;
    chk("wrap_count", 64'(got), 64'd10);
    tick();
    tick();
    tick();
    chk("wrap_no_extra", 64'(oMMU_VALID), 64'd0);
    chk("wrap_idle",     64'(oBUSY), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
